mul_issue_ctrl: RTL

- Wrapper stage that feeds the 16x9 sequential multiplier datapath and collects its 25-bit product.
- Upstream: accepts operand pairs over a valid/ready handshake into a 2-entry operand queue.
- Per operation: launches the multiplier by restarting its sequencer, holds operands stable, and waits a fixed iteration latency.
- Downstream: captures the product into an output register presented with a valid/ready handshake.

---
 rtl/mul_issue_ctrl.sv | 77 +++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: 2-deep operand queue that launches a sequential 16x9 multiplier
// and hands its 25-bit product downstream through a registered valid/ready stage.
module mul_issue_ctrl #(
  parameter int MUL_LAT = 11,
  parameter int QDEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_Mx,
  input  logic [8:0]  in_My,
  output logic [15:0] mul_Mx,
  output logic [8:0]  mul_My,
  output logic        mul_rst,
  input  logic [24:0] mul_Prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_Prod,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] ctr_q, ctr_d;
  logic [1:0] cnt_q, cnt_d, cnt_p;
  logic [24:0] q0_q, q0_d, q1_q, q1_d, op_q, op_d, out_prod_q, out_prod_d;
  logic out_valid_q, out_valid_d, push, pop, capture;
  assign in_ready = !RESET && cnt_q < 2'(QDEPTH);
  assign mul_rst = RESET || state_q == LAUNCH;
  assign busy = state_q != IDLE;
  assign mul_Mx = op_q[24:9];
  assign mul_My = op_q[8:0];
  assign out_valid = out_valid_q;
  assign out_Prod = out_prod_q;
  always_comb begin
    push = in_valid && in_ready;
    pop = state_q == IDLE && cnt_q != 2'd0;
    capture = state_q == DONE && (!out_valid_q || out_ready);
    // a same-cycle push lands behind whatever survives the pop
    cnt_p = pop ? cnt_q - 2'd1 : cnt_q;
    q0_d = (push && cnt_p == 2'd0) ? {in_Mx, in_My} : pop ? q1_q : q0_q;
    q1_d = (push && cnt_p != 2'd0) ? {in_Mx, in_My} : q1_q;
    cnt_d = cnt_p + {1'b0, push};
    op_d = pop ? q0_q : op_q;
    ctr_d = state_q == RUN ? ctr_q + 4'd1 : 4'd0;
    out_valid_d = capture || (out_valid_q && !out_ready);
    out_prod_d = capture ? mul_Prod : out_prod_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pop ? LAUNCH : IDLE;
      LAUNCH:  state_d = RUN;
      RUN:     state_d = ctr_q == 4'(MUL_LAT - 1) ? DONE : RUN;
      default: state_d = capture ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ctr_q <= '0;
      cnt_q <= '0;
      q0_q <= '0;
      q1_q <= '0;
      op_q <= '0;
      out_valid_q <= 1'b0;
      out_prod_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q <= ctr_d;
      cnt_q <= cnt_d;
      q0_q <= q0_d;
      q1_q <= q1_d;
      op_q <= op_d;
      out_valid_q <= out_valid_d;
      out_prod_q <= out_prod_d;
    end
  end
endmodule
